freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 19 +
 rtl/freq_meter_if.sv | 22 ++
 rtl/freq_meter_sync.sv | 27 ++
 rtl/freq_meter.sv | 112 +++++++++++
 tb/tb_freq_meter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and elaboration-time helpers for the frequency meter.
// Gate length is derived from the clock frequency and the requested gate time.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  function automatic int calc_gate_cycles(input int input_freq, input int gate_ms);
    return (input_freq / 1000) * gate_ms;
  endfunction

  function automatic int calc_tmr_w(input int gate_cycles);
    return $clog2(gate_cycles) + 1;
  endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle of the frequency meter; master = controller, slave = meter.
interface freq_meter_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             cont;
  logic             clear;
  logic [CNT_W-1:0] freq_count;
  logic             valid;
  logic             busy;
  logic             overflow;

  modport master (
    output start, cont, clear,
    input  freq_count, valid, busy, overflow
  );

  modport slave (
    input  start, cont, clear,
    output freq_count, valid, busy, overflow
  );
endinterface

// File: rtl/freq_meter_sync.sv
// Multi-flop synchronizer for the asynchronous input followed by a
// rising-edge detector producing a one-cycle pulse per edge.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic sig_in,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of sig_in over a fixed gate
// of GATE_CYCLES clocks and reports the count with a one-cycle valid.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for start; result registers hold
// ST_GATE   | gate open, timer running, edge pulses counted
// ST_REPORT | result registered, valid high; re-arm if cont
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int INPUT_FREQ  = 50_000_000,
  parameter int GATE_MS     = 1000,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic sig_in,
  freq_meter_if.slave bus
);

  localparam int GATE_CYCLES = calc_gate_cycles(INPUT_FREQ, GATE_MS);
  localparam int TMR_W       = calc_tmr_w(GATE_CYCLES);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cnt_ovf;
  logic [CNT_W-1:0] r_freq;
  logic             r_ovf;

  logic             w_pulse;
  logic             w_gate_end;
  logic             w_arm;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_ovf_nxt;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .o_pulse   (w_pulse)
  );

  assign w_gate_end = (r_state == ST_GATE) && (r_tmr == TMR_W'(GATE_CYCLES - 1));
  assign w_arm      = !bus.clear &&
                      (((r_state == ST_IDLE) && bus.start) ||
                       ((r_state == ST_REPORT) && bus.cont));

  // Saturating count; an edge arriving at full scale is lost and flagged.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_cnt_ovf_nxt = r_cnt_ovf;
    if ((r_state == ST_GATE) && w_pulse) begin
      if (&r_cnt) w_cnt_ovf_nxt = 1'b1;
      else        w_cnt_nxt     = r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:   if (bus.start) w_state_nxt = ST_GATE;
        ST_GATE:   if (w_gate_end) w_state_nxt = ST_REPORT;
        ST_REPORT: w_state_nxt = bus.cont ? ST_GATE : ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_cnt     <= '0;
      r_cnt_ovf <= 1'b0;
      r_freq    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arm) begin
        r_tmr     <= '0;
        r_cnt     <= '0;
        r_cnt_ovf <= 1'b0;
      end else if (r_state == ST_GATE) begin
        r_tmr     <= r_tmr + TMR_W'(1);
        r_cnt     <= w_cnt_nxt;
        r_cnt_ovf <= w_cnt_ovf_nxt;
      end
      // Capture the next-count so the final gate cycle's edge is included.
      if (w_gate_end && !bus.clear) begin
        r_freq <= w_cnt_nxt;
        r_ovf  <= w_cnt_ovf_nxt;
      end
    end
  end

  // busy bridges the report cycle when the next gate follows immediately.
  assign bus.busy       = (r_state == ST_GATE) ||
                          ((r_state == ST_REPORT) && bus.cont && !bus.clear);
  assign bus.valid      = (r_state == ST_REPORT);
  assign bus.freq_count = r_freq;
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter with a 100-cycle gate.
module tb_freq_meter;

  logic clk_50mhz;
  logic rst_n;
  logic sig_in;
  int   sig_per;
  int   phase;
  int   passed;
  int   total;

  freq_meter_if #(.CNT_W(8)) if_a ();
  freq_meter_if #(.CNT_W(5)) if_b ();

  freq_meter #(
    .INPUT_FREQ (100_000), .GATE_MS (1), .SYNC_STAGES (2), .CNT_W (8)
  ) dut_a (
    .clk_50mhz (clk_50mhz), .rst_n (rst_n), .sig_in (sig_in), .bus (if_a.slave)
  );

  freq_meter #(
    .INPUT_FREQ (100_000), .GATE_MS (1), .SYNC_STAGES (2), .CNT_W (5)
  ) dut_b (
    .clk_50mhz (clk_50mhz), .rst_n (rst_n), .sig_in (sig_in), .bus (if_b.slave)
  );

  initial begin
    clk_50mhz = 1'b0;
    forever #5 clk_50mhz = ~clk_50mhz;
  end

  // Periodic sig_in source; sig_per == 0 holds it low.
  initial begin
    sig_in = 1'b0;
    phase  = 0;
    forever begin
      @(posedge clk_50mhz);
      #2;
      phase++;
      sig_in = (sig_per == 0) ? 1'b0 : ((phase % sig_per) < (sig_per / 2));
    end
  end

  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic pulse_start_a();
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
  endtask

  // Observes dut_a for n cycles; sample i is taken i cycles after the call.
  task automatic run_window(input int n, input int exp_freq,
                            output int nvalid, output int nbusy, output int first_valid,
                            output int bad_gap, output int bad_freq,
                            output logic [7:0] last_freq, output logic last_ovf);
    int last_idx;
    nvalid = 0; nbusy = 0; first_valid = -1; bad_gap = 0; bad_freq = 0;
    last_idx = -1; last_freq = if_a.freq_count; last_ovf = if_a.overflow;
    for (int i = 0; i < n; i++) begin
      if (if_a.busy === 1'b1) nbusy++;
      if (if_a.valid === 1'b1) begin
        nvalid++;
        if (first_valid < 0) first_valid = i;
        if (last_idx >= 0 && (i - last_idx) != 101) bad_gap++;
        if (int'(if_a.freq_count) != exp_freq) bad_freq++;
        last_idx  = i;
        last_freq = if_a.freq_count;
        last_ovf  = if_a.overflow;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if ({if_a.valid, if_a.busy, if_a.overflow, if_a.freq_count} !== 11'd0)
      $display("FAIL reset_a: got v=%b b=%b o=%b f=%0d want all 0",
               if_a.valid, if_a.busy, if_a.overflow, if_a.freq_count);
    else passed++;
    total++;
    if ({if_b.valid, if_b.busy, if_b.overflow, if_b.freq_count} !== 8'd0)
      $display("FAIL reset_b: got v=%b b=%b o=%b f=%0d want all 0",
               if_b.valid, if_b.busy, if_b.overflow, if_b.freq_count);
    else passed++;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_single();
    int nv, nb, fv, bg, bf; logic [7:0] f; logic o;
    sig_per = 10;
    for (int i = 0; i < 5; i++) tick();
    pulse_start_a();
    run_window(130, 10, nv, nb, fv, bg, bf, f, o);
    total++; if (nv !== 1)  $display("FAIL single_valid_cnt: got %0d want 1", nv); else passed++;
    total++; if (f !== 8'd10) $display("FAIL single_freq: got %0d want 10", f); else passed++;
    total++; if (o !== 1'b0) $display("FAIL single_ovf: got %b want 0", o); else passed++;
    total++; if (nb !== 100) $display("FAIL single_busy_len: got %0d want 100", nb); else passed++;
    total++; if (fv !== 100) $display("FAIL single_valid_pos: got %0d want 100", fv); else passed++;
  endtask

  task automatic test_zero();
    int nv, nb, fv, bg, bf; logic [7:0] f; logic o;
    sig_per = 0;
    for (int i = 0; i < 6; i++) tick();
    pulse_start_a();
    run_window(130, 0, nv, nb, fv, bg, bf, f, o);
    total++; if (nv !== 1) $display("FAIL zero_valid_cnt: got %0d want 1", nv); else passed++;
    total++; if (f !== 8'd0) $display("FAIL zero_freq: got %0d want 0", f); else passed++;
  endtask

  task automatic test_overflow();
    int nv; logic [4:0] f; logic o;
    sig_per = 2;
    for (int i = 0; i < 6; i++) tick();
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    nv = 0; f = '0; o = 1'b0;
    for (int i = 0; i < 130; i++) begin
      if (if_b.valid === 1'b1) begin
        nv++; f = if_b.freq_count; o = if_b.overflow;
      end
      tick();
    end
    total++; if (nv !== 1) $display("FAIL ovf_valid_cnt: got %0d want 1", nv); else passed++;
    total++; if (f !== 5'd31) $display("FAIL ovf_freq: got %0d want 31", f); else passed++;
    total++; if (o !== 1'b1) $display("FAIL ovf_flag: got %b want 1", o); else passed++;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (if_b.freq_count !== 5'd31 || if_b.overflow !== 1'b1)
      $display("FAIL ovf_hold: got f=%0d o=%b want 31/1", if_b.freq_count, if_b.overflow);
    else passed++;
  endtask

  task automatic test_cont();
    int nv, nb, fv, bg, bf; logic [7:0] f; logic o;
    sig_per = 20;
    for (int i = 0; i < 6; i++) tick();
    if_a.cont = 1'b1;
    pulse_start_a();
    run_window(320, 5, nv, nb, fv, bg, bf, f, o);
    total++; if (nv !== 3) $display("FAIL cont_valid_cnt: got %0d want 3", nv); else passed++;
    total++; if (fv !== 100) $display("FAIL cont_first_valid: got %0d want 100", fv); else passed++;
    total++; if (bg !== 0) $display("FAIL cont_gap: got %0d bad gaps want 0", bg); else passed++;
    total++; if (bf !== 0) $display("FAIL cont_freq: got %0d wrong counts want 0", bf); else passed++;
    total++; if (nb !== 320) $display("FAIL cont_busy: got %0d busy cycles want 320", nb); else passed++;
    if_a.cont = 1'b0;
    for (int i = 0; i < 150; i++) tick();
    total++;
    if (if_a.busy !== 1'b0 || if_a.freq_count !== 8'd5)
      $display("FAIL cont_stop: got busy=%b f=%0d want 0/5", if_a.busy, if_a.freq_count);
    else passed++;
  endtask

  task automatic test_clear();
    int nv, nb, fv, bg, bf; logic [7:0] f; logic o;
    sig_per = 10;
    for (int i = 0; i < 6; i++) tick();
    pulse_start_a();
    for (int i = 0; i < 50; i++) tick();
    if_a.clear = 1'b1;
    if_a.start = 1'b1;
    tick();
    if_a.clear = 1'b0;
    if_a.start = 1'b0;
    total++;
    if (if_a.busy !== 1'b0 || if_a.valid !== 1'b0)
      $display("FAIL clear_idle: got busy=%b valid=%b want 0/0", if_a.busy, if_a.valid);
    else passed++;
    run_window(130, 5, nv, nb, fv, bg, bf, f, o);
    total++; if (nv !== 0) $display("FAIL clear_no_valid: got %0d want 0", nv); else passed++;
    total++; if (if_a.freq_count !== 8'd5) $display("FAIL clear_hold: got %0d want 5", if_a.freq_count); else passed++;
  endtask

  task automatic test_start_ignored();
    int nv, nb, fv, bg, bf; logic [7:0] f; logic o;
    pulse_start_a();
    for (int i = 0; i < 30; i++) tick();
    pulse_start_a();
    run_window(120, 10, nv, nb, fv, bg, bf, f, o);
    total++; if (nv !== 1) $display("FAIL restart_valid_cnt: got %0d want 1", nv); else passed++;
    total++; if (fv !== 69) $display("FAIL restart_valid_pos: got %0d want 69", fv); else passed++;
    total++; if (f !== 8'd10) $display("FAIL restart_freq: got %0d want 10", f); else passed++;
  endtask

  task automatic test_reset_mid();
    int nv, nb, fv, bg, bf; logic [7:0] f; logic o;
    pulse_start_a();
    for (int i = 0; i < 30; i++) tick();
    rst_n = 1'b0;
    #2;
    total++;
    if ({if_a.valid, if_a.busy, if_a.overflow, if_a.freq_count} !== 11'd0)
      $display("FAIL rstmid_outputs: got v=%b b=%b o=%b f=%0d want all 0",
               if_a.valid, if_a.busy, if_a.overflow, if_a.freq_count);
    else passed++;
    tick(); tick();
    rst_n = 1'b1;
    run_window(150, 0, nv, nb, fv, bg, bf, f, o);
    total++; if (nv !== 0 || nb !== 0) $display("FAIL rstmid_quiet: got valid=%0d busy=%0d want 0/0", nv, nb); else passed++;
    pulse_start_a();
    run_window(130, 10, nv, nb, fv, bg, bf, f, o);
    total++; if (nv !== 1 || f !== 8'd10) $display("FAIL rstmid_restart: got valid=%0d f=%0d want 1/10", nv, f); else passed++;
  endtask

  initial begin
    passed = 0; total = 0; sig_per = 0;
    rst_n = 1'b1;
    if_a.start = 1'b0; if_a.cont = 1'b0; if_a.clear = 1'b0;
    if_b.start = 1'b0; if_b.cont = 1'b0; if_b.clear = 1'b0;
    #1;
    test_reset();
    test_single();
    test_zero();
    test_overflow();
    test_cont();
    test_clear();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
